// File: rtl/mult_arbiter.sv
// -----------------------------------------------------------------------------
// mult_arbiter
//
// Round-robin arbiter and sequencer in front of one shared combinational 8x8
// multiplier. The winning requester's operands are registered onto mul_a_o and
// mul_b_o. They are held for SETTLE_CYCLES clocks so the multiplier ripple can
// settle. The product is then captured and returned with a one-cycle ack.
//
// Parameters
//   NUM_REQ        number of requesters (2..8)
//   SETTLE_CYCLES  clocks the multiplier inputs are held before sampling (>=1)
//
// Optional build macro
//   MULT_ARB_ZERO_BYPASS_EN  when defined, a winner with a zero operand skips
//                            the settle phase and is acknowledged with a zero
//                            product on the next cycle.
//
// Ports
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   req_i         per-requester request level, held until ack
//   req_a_i       operand A per requester, slot i = bits [8i+7:8i]
//   req_b_i       operand B per requester, same packing
//   ack_o         one-hot single-cycle acknowledge to the served requester
//   resp_valid_o  high in the ack cycle
//   resp_id_o     index of the served requester
//   resp_prod_o   product, qualified by resp_valid_o
//   busy_o        high while an operation is settling or completing
//   mul_a_o       registered operand A to the multiplier
//   mul_b_o       registered operand B to the multiplier
//   mul_prod_i    multiplier product (combinational from mul_a_o/mul_b_o)
// -----------------------------------------------------------------------------
module mult_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int SETTLE_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_i,
    input  logic [8*NUM_REQ-1:0]   req_a_i,
    input  logic [8*NUM_REQ-1:0]   req_b_i,
    output logic [NUM_REQ-1:0]     ack_o,
    output logic                   resp_valid_o,
    output logic [2:0]             resp_id_o,
    output logic [15:0]            resp_prod_o,
    output logic                   busy_o,
    output logic [7:0]             mul_a_o,
    output logic [7:0]             mul_b_o,
    input  logic [15:0]            mul_prod_i
);

    localparam int                 CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]         LAST_RST = 3'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] REQ_ONE  = NUM_REQ'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           id_q, id_d;
    logic [2:0]           last_grant_q, last_grant_d;
    logic [7:0]           mul_a_q, mul_a_d;
    logic [7:0]           mul_b_q, mul_b_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic                 resp_valid_q, resp_valid_d;
    logic [2:0]           resp_id_q, resp_id_d;
    // Doubles as the captured product register: loaded on the SETTLE->DONE
    // edge and held afterwards.
    logic [15:0]          resp_prod_q, resp_prod_d;
    logic                 busy_q, busy_d;

    logic                 win_found_s;
    logic [2:0]           win_id_s;
    logic [7:0]           win_a_s;
    logic [7:0]           win_b_s;

    function automatic logic [NUM_REQ-1:0] onehot(input logic [2:0] idx);
        return REQ_ONE << idx;
    endfunction

    // Round-robin winner: first set request scanning upward from last_grant+1.
    always_comb begin
        win_found_s = 1'b0;
        win_id_s    = 3'd0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!win_found_s &&
                (((req_i >> ((int'(last_grant_q) + k) % NUM_REQ)) & REQ_ONE) != '0)) begin
                win_found_s = 1'b1;
                win_id_s    = 3'((int'(last_grant_q) + k) % NUM_REQ);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Operand slot of the current winner.
    always_comb begin
        win_a_s = 8'(req_a_i >> (8 * int'(win_id_s)));
        win_b_s = 8'(req_b_i >> (8 * int'(win_id_s)));
    end

    // Next-state and registered-output logic of the sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        ack_d        = '0;
        resp_valid_d = 1'b0;
        resp_id_d    = resp_id_q;
        resp_prod_d  = resp_prod_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found_s) begin
                    mul_a_d = win_a_s;
                    mul_b_d = win_b_s;
                    id_d    = win_id_s;
                    cnt_d   = CNT_LOAD;
`ifdef MULT_ARB_ZERO_BYPASS_EN
                    // A zero operand makes the product known: skip settling.
                    if ((win_a_s == 8'd0) || (win_b_s == 8'd0)) begin
                        state_d      = ST_DONE;
                        ack_d        = onehot(win_id_s);
                        resp_valid_d = 1'b1;
                        resp_id_d    = win_id_s;
                        resp_prod_d  = 16'd0;
                    end else begin
                        state_d = ST_SETTLE;
                    end
`else
                    state_d = ST_SETTLE;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    // Outputs are registered, so the DONE-cycle response is
                    // loaded on the edge that enters DONE.
                    state_d      = ST_DONE;
                    ack_d        = onehot(id_q);
                    resp_valid_d = 1'b1;
                    resp_id_d    = id_q;
                    resp_prod_d  = mul_prod_i;
                end
            end
            ST_DONE: begin
                last_grant_d = id_q;
                state_d      = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            id_q         <= 3'd0;
            last_grant_q <= LAST_RST;
            mul_a_q      <= 8'd0;
            mul_b_q      <= 8'd0;
            ack_q        <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 3'd0;
            resp_prod_q  <= 16'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            ack_q        <= ack_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_prod_q  <= resp_prod_d;
            busy_q       <= busy_d;
        end
    end

    assign ack_o        = ack_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_prod_o  = resp_prod_q;
    assign busy_o       = busy_q;
    assign mul_a_o      = mul_a_q;
    assign mul_b_o      = mul_b_q;

endmodule

// File: tb/tb_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mult_arbiter: self-checking bench for mult_arbiter.
// The multiplier is modelled with a settling behaviour: its output is only the
// true product once mul_a/mul_b have been stable for SETTLE_CYCLES clocks.
// -----------------------------------------------------------------------------
module tb_mult_arbiter;

    localparam int NUM_REQ = 4;
    localparam int S       = 3;
`ifdef MULT_ARB_ZERO_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NUM_REQ-1:0]   req = '0;
    logic [8*NUM_REQ-1:0] req_a = '0;
    logic [8*NUM_REQ-1:0] req_b = '0;
    logic [NUM_REQ-1:0]   ack;
    logic                 resp_valid;
    logic [2:0]           resp_id;
    logic [15:0]          resp_prod;
    logic                 busy;
    logic [7:0]           mul_a;
    logic [7:0]           mul_b;
    logic [15:0]          mul_prod;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int age     = 0;
    logic [7:0] prev_a = 8'd0;
    logic [7:0] prev_b = 8'd0;

    mult_arbiter #(.NUM_REQ(NUM_REQ), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req), .req_a_i(req_a), .req_b_i(req_b),
        .ack_o(ack), .resp_valid_o(resp_valid), .resp_id_o(resp_id),
        .resp_prod_o(resp_prod), .busy_o(busy), .mul_a_o(mul_a), .mul_b_o(mul_b),
        .mul_prod_i(mul_prod)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Settling multiplier: count cycles the inputs have been stable.
    always @(posedge clk) begin
        #1;
        if (mul_a != prev_a || mul_b != prev_b) age <= 1;
        else if (age < 1000) age <= age + 1;
        prev_a <= mul_a;
        prev_b <= mul_b;
    end
    assign mul_prod = (age >= S) ? (16'(mul_a) * 16'(mul_b)) : 16'hBAD0;

    function automatic logic [7:0] nz();
        return 8'($urandom_range(255, 1));
    endfunction

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '1;
        for (int i = 0; i < NUM_REQ; i++) set_op(i, nz(), nz());
        @(negedge clk); @(negedge clk); @(negedge clk);
        n_tests++; if (ack !== '0) begin n_fail++; $display("FAIL reset_ack: got %h want 0", ack); end
        n_tests++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        n_tests++; if (resp_id !== 3'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", resp_id); end
        n_tests++; if (resp_prod !== 16'd0) begin n_fail++; $display("FAIL reset_prod: got %h want 0", resp_prod); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_tests++; if (mul_a !== 8'd0 || mul_b !== 8'd0) begin n_fail++; $display("FAIL reset_mul: got %h/%h want 0/0", mul_a, mul_b); end
        req = '0;
    endtask

    task automatic test_single();
        logic want_v;
        do_reset();
        set_op(0, 8'd12, 8'd10);
        req = 4'b0001;
        for (int k = 1; k <= S + 2; k++) begin
            @(negedge clk);
            want_v = (k == S + 1);
            n_tests++; if (ack !== (want_v ? 4'b0001 : 4'b0000)) begin n_fail++; $display("FAIL single_ack T+%0d: got %b want %b", k, ack, want_v ? 4'b0001 : 4'b0000); end
            n_tests++; if (resp_valid !== want_v) begin n_fail++; $display("FAIL single_valid T+%0d: got %b want %b", k, resp_valid, want_v); end
            n_tests++; if (busy !== (k <= S + 1)) begin n_fail++; $display("FAIL single_busy T+%0d: got %b want %b", k, busy, (k <= S + 1)); end
            if (k <= S) begin
                n_tests++; if (mul_a !== 8'd12 || mul_b !== 8'd10) begin n_fail++; $display("FAIL single_mul T+%0d: got %0d/%0d want 12/10", k, mul_a, mul_b); end
            end
            if (want_v) begin
                n_tests++; if (resp_id !== 3'd0) begin n_fail++; $display("FAIL single_id: got %0d want 0", resp_id); end
                n_tests++; if (resp_prod !== 16'h0078) begin n_fail++; $display("FAIL single_prod: got %h want 0078", resp_prod); end
                req = '0;
            end
        end
    endtask

    // Holds a fixed request pattern and checks grant order, spacing, products.
    task automatic test_simultaneous();
        int start, prev, want;
        logic got;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, nz(), nz());
        req = 4'b0101;
        start = cyc;
        prev  = cyc;
        for (int j = 0; j < 4; j++) begin
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                @(negedge clk);
                if (ack != '0) got = 1'b1;
            end
            want = (j % 2 == 0) ? 0 : 2;
            n_tests++;
            if (!got) begin
                n_fail++; $display("FAIL simul_timeout: ack %0d never seen", j);
            end else begin
                if (resp_id !== 3'(want) || ack !== (4'b0001 << want) ||
                    resp_prod !== 16'(req_a[8*want +: 8]) * 16'(req_b[8*want +: 8]) ||
                    (cyc - ((j == 0) ? start : prev)) != ((j == 0) ? S + 1 : S + 2)) begin
                    n_fail++;
                    $display("FAIL simul_grant %0d: got id %0d ack %b prod %h gap %0d want id %0d prod %h",
                             j, resp_id, ack, resp_prod, cyc - ((j == 0) ? start : prev), want,
                             16'(req_a[8*want +: 8]) * 16'(req_b[8*want +: 8]));
                end
                prev = cyc;
            end
        end
        req = '0;
    endtask

    task automatic test_fairness();
        logic got;
        int   want;
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) set_op(i, nz(), nz());
        req = '1;
        for (int j = 0; j < 6; j++) begin
            got = 1'b0;
            for (int w = 0; w < 40 && !got; w++) begin
                @(negedge clk);
                if (ack != '0) got = 1'b1;
            end
            want = j % NUM_REQ;
            n_tests++;
            if (!got) begin
                n_fail++; $display("FAIL fair_timeout: ack %0d never seen", j);
            end else if (resp_id !== 3'(want) ||
                         resp_prod !== 16'(req_a[8*want +: 8]) * 16'(req_b[8*want +: 8])) begin
                n_fail++; $display("FAIL fair_order %0d: got id %0d prod %h want id %0d", j, resp_id, resp_prod, want);
            end
        end
        req = '0;
    endtask

    task automatic test_reset_mid_settle();
        logic got;
        int   rs;
        do_reset();
        set_op(0, nz(), nz());
        set_op(1, nz(), nz());
        req = 4'b0011;
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        n_tests++; if (!got || resp_id !== 3'd0) begin n_fail++; $display("FAIL rstmid_first: got seen=%b id %0d want id 0", got, resp_id); end
        @(negedge clk);          // IDLE: requester 1 wins at this edge
        @(negedge clk);          // SETTLE
        n_tests++; if (busy !== 1'b1 || mul_a !== req_a[15:8]) begin n_fail++; $display("FAIL rstmid_inflight: busy %b mul_a %h want 1/%h", busy, mul_a, req_a[15:8]); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_tests++;
        if (ack !== '0 || resp_valid !== 1'b0 || resp_id !== 3'd0 || resp_prod !== 16'd0 ||
            busy !== 1'b0 || mul_a !== 8'd0 || mul_b !== 8'd0) begin
            n_fail++;
            $display("FAIL rstmid_clear: ack %b v %b id %0d prod %h busy %b mul %h/%h want all 0",
                     ack, resp_valid, resp_id, resp_prod, busy, mul_a, mul_b);
        end
        rs  = cyc;
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        n_tests++;
        if (!got || resp_id !== 3'd0 || (cyc - rs) != S + 1) begin
            n_fail++; $display("FAIL rstmid_reserve: seen %b id %0d latency %0d want id 0 latency %0d", got, resp_id, cyc - rs, S + 1);
        end
        req = '0;
    endtask

    task automatic test_operand_change();
        logic [7:0] b;
        logic       got;
        int         t0;
        do_reset();
        b = nz();
        set_op(1, 8'd5, b);
        req = 4'b0010;
        t0  = cyc;
        @(negedge clk);
        n_tests++; if (mul_a !== 8'd5) begin n_fail++; $display("FAIL opchg_mul_a: got %0d want 5", mul_a); end
        set_op(1, 8'd9, nz());
        req = '0;
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            if (ack == '0) @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        n_tests++;
        if (!got || resp_id !== 3'd1 || resp_prod !== 16'(b) * 16'd5 || (cyc - t0) != S + 1) begin
            n_fail++; $display("FAIL opchg_result: seen %b id %0d prod %h lat %0d want id 1 prod %h lat %0d",
                               got, resp_id, resp_prod, cyc - t0, 16'(b) * 16'd5, S + 1);
        end
    endtask

    task automatic test_zero();
        logic got;
        int   t0;
        do_reset();
        set_op(0, 8'd0, 8'd77);
        req = 4'b0001;
        t0  = cyc;
        got = 1'b0;
        for (int w = 0; w < 40 && !got; w++) begin
            @(negedge clk);
            if (ack != '0) got = 1'b1;
        end
        n_tests++;
        if (!got || resp_id !== 3'd0 || resp_prod !== 16'd0 || (cyc - t0) != (BYPASS ? 1 : S + 1)) begin
            n_fail++; $display("FAIL zero_op: seen %b id %0d prod %h lat %0d want id 0 prod 0 lat %0d",
                               got, resp_id, resp_prod, cyc - t0, BYPASS ? 1 : S + 1);
        end
        req = '0;
    endtask

    // Random traffic against a transaction-level model: a round-robin pointer,
    // one outstanding operation with its grant cycle and due cycle.
    task automatic test_random();
        int lg, win, gc, due, free_at, c;
        logic pend;
        logic [7:0] ea, eb;
        logic [15:0] eprod;
        logic [NUM_REQ-1:0] eack;
        do_reset();
        lg = NUM_REQ - 1; pend = 1'b0; free_at = cyc; win = 0; gc = 0; due = 0; eprod = 16'd0;
        for (int n = 0; n < 2000; n++) begin
            c    = cyc;
            eack = (pend && c == due) ? (NUM_REQ'(1) << win) : '0;
            n_tests++;
            if (ack !== eack || resp_valid !== (eack != '0) || busy !== (pend && c > gc)) begin
                n_fail++; $display("FAIL rand_ctl cyc %0d: ack %b v %b busy %b want ack %b v %b busy %b",
                                   c, ack, resp_valid, busy, eack, (eack != '0), (pend && c > gc));
            end
            if (eack != '0) begin
                n_tests++;
                if (resp_id !== 3'(win) || resp_prod !== eprod) begin
                    n_fail++; $display("FAIL rand_resp cyc %0d: id %0d prod %h want id %0d prod %h", c, resp_id, resp_prod, win, eprod);
                end
                lg = win; pend = 1'b0; free_at = c + 1;
            end
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req[i] && eack[i]) begin
                    if ($urandom_range(1, 0) == 0) req[i] = 1'b0;
                    else set_op(i, ($urandom_range(7, 0) == 0) ? 8'd0 : nz(), nz());
                end else if (!req[i] && $urandom_range(2, 0) == 0) begin
                    req[i] = 1'b1;
                    set_op(i, ($urandom_range(7, 0) == 0) ? 8'd0 : nz(),
                              ($urandom_range(7, 0) == 0) ? 8'd0 : nz());
                end else if ($urandom_range(9, 0) == 0) begin
                    set_op(i, nz(), nz());
                end else if (pend && i == win && req[i] && $urandom_range(19, 0) == 0) begin
                    req[i] = 1'b0;
                end
            end
            if (!pend && c >= free_at && req != '0) begin
                for (int k = 1; k <= NUM_REQ; k++) begin
                    if (!pend && req[(lg + k) % NUM_REQ]) begin
                        win  = (lg + k) % NUM_REQ;
                        pend = 1'b1;
                    end
                end
                ea    = req_a[8*win +: 8];
                eb    = req_b[8*win +: 8];
                eprod = 16'(ea) * 16'(eb);
                gc    = c;
                due   = (BYPASS && (ea == 8'd0 || eb == 8'd0)) ? c + 1 : c + S + 1;
            end
            @(negedge clk);
        end
        req = '0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_fairness();
        test_reset_mid_settle();
        test_operand_change();
        test_zero();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
